// File: rtl/vram_pkg.sv
// Shared definitions for the screen character RAM arbiter.
//   ADDR_W/DATA_W : default RAM geometry (4096 x 8)
//   COLS/ROWS     : visible text area (80 x 25)
//   COL_W/ROW_W   : widths of the col/row fields in {row, col} addresses
//   owner_e       : who a RAM read belongs to
//   clr_state_e   : clear engine FSM states (used with VRAM_ARBITER_CLEAR_EN)
package vram_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_FILL = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Read tag pipeline: an RD_LAT-deep shift register of {valid, owner} that
// tracks each granted read until the RAM returns its data.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_owner : tag of the read granted this cycle
//   out_valid/out_owner : tag aligned with ram_q_i
module vram_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [RD_LAT:0] valid_chain;
  logic [RD_LAT:0] owner_chain;

  assign valid_chain[0] = in_valid;
  assign owner_chain[0] = in_owner;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic valid_reg;
      logic owner_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          owner_reg <= 1'b0;
        end else begin
          valid_reg <= valid_chain[gi];
          owner_reg <= owner_chain[gi];
        end
      end

      assign valid_chain[gi+1] = valid_reg;
      assign owner_chain[gi+1] = owner_reg;
    end
  endgenerate

  assign out_valid = valid_chain[RD_LAT];
  assign out_owner = owner_chain[RD_LAT];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port arbiter for the 4096x8 screen character RAM.
// The display fetch has hard priority and is never stalled; the host edit
// port is served (req/ack) in any cycle without a display request.
// Optional clear engine enabled by macro VRAM_ARBITER_CLEAR_EN: fills the
// 80x25 visible area with CLR_CHAR, priority display > clear > host.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   disp_req_i/disp_addr_i         : display read request and address
//   disp_data_o/disp_valid_o       : display read data and strobe
//   host_req_i/we/addr/wdata       : host request, held until host_ack_o
//   host_ack_o                     : one-cycle grant pulse
//   host_rdata_o/host_rvalid_o     : host read data and strobe
//   ram_addr_o/ram_data_o/ram_wren_o/ram_q_i : RAM interface
//   clear_i/clear_busy_o           : clear start (rising edge) / busy (macro only)
module vram_arbiter #(
  parameter int          ADDR_W   = 12,
  parameter int          DATA_W   = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
`ifdef VRAM_ARBITER_CLEAR_EN
  input  logic              clear_i,
  output logic              clear_busy_o,
`endif
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  import vram_pkg::*;

  logic              fill_busy;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

  assign fill_data = DATA_W'(CLR_CHAR);

`ifdef VRAM_ARBITER_CLEAR_EN
  clr_state_e        state_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic              clear_d_reg;
  logic              clear_rise;

  assign clear_rise   = clear_i & ~clear_d_reg;
  assign fill_busy    = (state_reg == CLR_FILL);
  assign fill_addr    = ADDR_W'({row_reg, col_reg});
  assign clear_busy_o = fill_busy;

  // Counters only advance on cycles the fill actually owns the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLR_IDLE;
      row_reg     <= '0;
      col_reg     <= '0;
      clear_d_reg <= 1'b0;
    end else begin
      clear_d_reg <= clear_i;
      case (state_reg)
        CLR_IDLE: begin
          if (clear_rise) begin
            state_reg <= CLR_FILL;
            row_reg   <= '0;
            col_reg   <= '0;
          end
        end
        CLR_FILL: begin
          if (clear_rise) begin
            row_reg <= '0;
            col_reg <= '0;
          end else if (!disp_req_i) begin
            if (col_reg == COL_W'(COLS - 1)) begin
              col_reg <= '0;
              if (row_reg == ROW_W'(ROWS - 1)) begin
                state_reg <= CLR_IDLE;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        default: state_reg <= CLR_IDLE;
      endcase
    end
  end
`else
  assign fill_busy = 1'b0;
  assign fill_addr = '0;
`endif

  logic [ADDR_W-1:0] addr_hold_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              wren_next;
  logic              ack_next;
  logic              rd_load;
  owner_e            rd_owner;

  // Priority mux: display > clear fill > host > idle (address holds).
  always_comb begin
    addr_next  = addr_hold_reg;
    wdata_next = '0;
    wren_next  = 1'b0;
    ack_next   = 1'b0;
    if (disp_req_i) begin
      addr_next = disp_addr_i;
    end else if (fill_busy) begin
      addr_next  = fill_addr;
      wdata_next = fill_data;
      wren_next  = 1'b1;
    end else if (host_req_i) begin
      ack_next  = 1'b1;
      addr_next = host_addr_i;
      if (host_we_i) begin
        wren_next  = 1'b1;
        wdata_next = host_wdata_i;
      end
    end
  end

  // Grant outputs are forced low while reset is held so nothing reaches
  // the RAM or the host during reset.
  assign ram_addr_o = rst ? '0 : addr_next;
  assign ram_data_o = rst ? '0 : wdata_next;
  assign ram_wren_o = rst ? 1'b0 : wren_next;
  assign host_ack_o = rst ? 1'b0 : ack_next;

  assign rd_load  = disp_req_i | (ack_next & ~host_we_i);
  assign rd_owner = disp_req_i ? OWN_DISP : OWN_HOST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_reg <= '0;
    end else begin
      addr_hold_reg <= addr_next;
    end
  end

  logic pipe_valid;
  logic pipe_owner;

  vram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_load),
    .in_owner  (rd_owner),
    .out_valid (pipe_valid),
    .out_owner (pipe_owner)
  );

  // Capture RAM data for whichever port issued the read; data holds
  // between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data_o   <= '0;
      disp_valid_o  <= 1'b0;
      host_rdata_o  <= '0;
      host_rvalid_o <= 1'b0;
    end else begin
      disp_valid_o  <= 1'b0;
      host_rvalid_o <= 1'b0;
      if (pipe_valid) begin
        if (pipe_owner == OWN_HOST) begin
          host_rdata_o  <= ram_q_i;
          host_rvalid_o <= 1'b1;
        end else begin
          disp_data_o  <= ram_q_i;
          disp_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter (RD_LAT=1) with a behavioural
// 4096x8 RAM with one-cycle registered read.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q;
`ifdef VRAM_ARBITER_CLEAR_EN
  logic        clear = 1'b0;
  logic        clear_busy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(1), .CLR_CHAR(8'h20)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_req_i    (disp_req),
    .disp_addr_i   (disp_addr),
    .disp_data_o   (disp_data),
    .disp_valid_o  (disp_valid),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_ack_o    (host_ack),
    .host_rdata_o  (host_rdata),
    .host_rvalid_o (host_rvalid),
`ifdef VRAM_ARBITER_CLEAR_EN
    .clear_i       (clear),
    .clear_busy_o  (clear_busy),
`endif
    .ram_addr_o    (ram_addr),
    .ram_data_o    (ram_data),
    .ram_wren_o    (ram_wren),
    .ram_q_i       (ram_q)
  );

  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dr, input logic [11:0] da, input logic hr,
                       input logic hw, input logic [11:0] ha, input logic [7:0] hd);
    disp_req = dr; disp_addr = da;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ack"}, host_ack, 0);
    check({tag, ".wren"}, ram_wren, 0);
    check({tag, ".addr"}, ram_addr, 0);
    check({tag, ".wdata"}, ram_data, 0);
    check({tag, ".dvalid"}, disp_valid, 0);
    check({tag, ".hvalid"}, host_rvalid, 0);
    check({tag, ".ddata"}, disp_data, 0);
    check({tag, ".hrdata"}, host_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Host write 41 -> 085, then read back
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h085, 8'h41);
    @(negedge clk);
    check("wr.ack", host_ack, 1);
    check("wr.wren", ram_wren, 1);
    check("wr.addr", ram_addr, 12'h085);
    check("wr.wdata", ram_data, 8'h41);
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 1'b0, 12'h085, 8'h00);
    @(negedge clk);
    check("rd.ack", host_ack, 1);
    check("rd.wren", ram_wren, 0);
    check("rd.addr", ram_addr, 12'h085);
    next_cycle();
    drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
    @(negedge clk);
    check("rd.hvalid_early", host_rvalid, 0);
    check("idle.addr_hold", ram_addr, 12'h085);
    check("idle.wren", ram_wren, 0);
    next_cycle();
    @(negedge clk);
    check("rd.hvalid", host_rvalid, 1);
    check("rd.hrdata", host_rdata, 8'h41);
    check("rd.dvalid", disp_valid, 0);
    next_cycle();
    @(negedge clk);
    check("rd.hvalid_pulse", host_rvalid, 0);
    check("rd.hrdata_hold", host_rdata, 8'h41);

    // Display holds the RAM for 10 cycles while host waits
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 12'h010, 1'b1, 1'b1, 12'h123, 8'h55);
      @(negedge clk);
      check($sformatf("stall%0d.ack", i), host_ack, 0);
      check($sformatf("stall%0d.wren", i), ram_wren, 0);
      check($sformatf("stall%0d.addr", i), ram_addr, 12'h010);
    end
    next_cycle();
    drive(1'b0, 12'h010, 1'b1, 1'b1, 12'h123, 8'h55);
    @(negedge clk);
    check("unstall.ack", host_ack, 1);
    check("unstall.wren", ram_wren, 1);
    check("unstall.addr", ram_addr, 12'h123);
    idle(3);

    // Back-to-back host writes: ack every cycle
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 8'hA0);
    @(negedge clk);
    check("b2b0.ack", host_ack, 1);
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 8'hB1);
    @(negedge clk);
    check("b2b1.ack", host_ack, 1);
    check("b2b1.addr", ram_addr, 12'h001);
    idle(3);

    // Interleaved display (000) and host (001) reads
    for (int k = 0; k < 10; k++) begin
      int j;
      next_cycle();
      drive((k < 8) && (k % 2 == 0), 12'h000, (k < 8), 1'b0, 12'h001, 8'h00);
      @(negedge clk);
      check($sformatf("il%0d.ack", k), host_ack, ((k < 8) && (k % 2 == 1)) ? 1 : 0);
      if (k >= 2) begin
        j = k - 2;
        check($sformatf("il%0d.dvalid", k), disp_valid, (j % 2 == 0) ? 1 : 0);
        check($sformatf("il%0d.hvalid", k), host_rvalid, (j % 2 == 1) ? 1 : 0);
        if (j % 2 == 0) check($sformatf("il%0d.ddata", k), disp_data, 8'hA0);
        else            check($sformatf("il%0d.hrdata", k), host_rdata, 8'hB1);
      end
    end
    idle(2);

    // Reset one cycle after a host read grant drops the read
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 1'b0, 12'h085, 8'h00);
    @(negedge clk);
    check("rstrd.ack", host_ack, 1);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 12'h7FF, 1'b1, 1'b1, 12'h3AB, 8'hCC);
    @(negedge clk);
    check_all_zero("inrst0");
    next_cycle();
    @(negedge clk);
    check_all_zero("inrst1");
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postrst%0d.hvalid", i), host_rvalid, 0);
      check($sformatf("postrst%0d.dvalid", i), disp_valid, 0);
      next_cycle();
    end

`ifdef VRAM_ARBITER_CLEAR_EN
    begin
      int nw, bad, hit, viol;
      logic [11:0] last;
      logic seen, done;
      // Full clear with no display traffic
      nw = 0; bad = 0; hit = 0; seen = 0; done = 0; last = '0;
      next_cycle();
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
      for (int c = 0; c < 2100 && !done; c++) begin
        @(negedge clk);
        if (ram_wren) begin
          nw++;
          if (ram_data != 8'h20) bad++;
          if (ram_addr == 12'h050) hit++;
          last = ram_addr;
        end
        if (seen && !clear_busy) done = 1;
        if (clear_busy) seen = 1;
        next_cycle();
      end
      check("clr.done", done, 1);
      check("clr.writes", nw, 2000);
      check("clr.baddata", bad, 0);
      check("clr.col80", hit, 0);
      check("clr.last", last, 12'hC4F);

      // Restart mid-fill with a pending host write
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
      repeat (50) next_cycle();
      clear = 1'b1;
      drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h300, 8'h77);
      @(negedge clk);
      check("rstrt.ack0", host_ack, 0);
      next_cycle();
      clear = 1'b0;
      @(negedge clk);
      check("rstrt.addr", ram_addr, 12'h000);
      viol = 0; done = 0;
      for (int c = 0; c < 2100 && !done; c++) begin
        @(negedge clk);
        if (clear_busy) begin
          if (host_ack) viol++;
          next_cycle();
        end else begin
          done = 1;
        end
      end
      check("rstrt.done", done, 1);
      check("rstrt.ackviol", viol, 0);
      check("rstrt.ack", host_ack, 1);
      check("rstrt.haddr", ram_addr, 12'h300);
      idle(2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
